// File: rtl/poli_crc_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : poli_crc_sequencer
// Purpose  : Bit-serial CRC sequencer driving an external polymorphic XOR/BUF
//            cell array; the cell orient vector carries the generator polynomial.
// Revision : 1.0 - initial release
// ============================================================================
module poli_crc_sequencer #(
    parameter int W             = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic [W-1:0] cfg_poly,
    input  logic [W-1:0] cfg_init,
    input  logic         start,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic         busy,
    output logic [W-1:0] crc_out,
    output logic [W-1:0] poli_A,
    output logic [W-1:0] poli_B,
    output logic [W-1:0] poli_orient,
    output logic         poli_output_select,
    input  logic [W-1:0] poli_X
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       crc_q, crc_d;
    logic [W-1:0]       poly_q, poly_d;
    logic [7:0]         data_q, data_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   settle_cnt_q, settle_cnt_d;

    logic               w_active;
    logic               w_fb;
    logic               w_ready;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= S_IDLE;
            crc_q        <= '0;
            poly_q       <= '0;
            data_q       <= '0;
            bit_idx_q    <= 3'd7;
            settle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            crc_q        <= crc_d;
            poly_q       <= poly_d;
            data_q       <= data_d;
            bit_idx_q    <= bit_idx_d;
            settle_cnt_q <= settle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        crc_d        = crc_q;
        poly_d       = poly_q;
        data_d       = data_q;
        bit_idx_d    = bit_idx_q;
        settle_cnt_d = settle_cnt_q;

        // in_ready is gated by nRST so it stays low for the whole reset window
        w_ready  = (state_q == S_IDLE) && nRST && !start;
        w_active = (state_q == S_SETTLE) || (state_q == S_CAPTURE);
        w_fb     = crc_q[W-1] ^ data_q[bit_idx_q];

        in_ready           = w_ready;
        busy               = w_active;
        poli_output_select = w_active;
        poli_A             = '0;
        poli_B             = '0;
        poli_orient        = '0;
        if (w_active) begin
            poli_A      = {crc_q[W-2:0], 1'b0};
            poli_B      = {W{w_fb}};
            poli_orient = poly_q;
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid && w_ready) begin
                    poly_d       = cfg_poly;
                    data_d       = in_data;
                    bit_idx_d    = 3'd7;
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end
            end
            S_SETTLE: begin
                settle_cnt_d = settle_cnt_q + CNT_W'(1);
                if (settle_cnt_q == C_SETTLE_LAST) begin
                    state_d = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                crc_d = poli_X;
                if (bit_idx_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    bit_idx_d    = bit_idx_q - 3'd1;
                    settle_cnt_d = '0;
                    state_d      = S_SETTLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // start overrides everything, including a capture on the same cycle
        if (start) begin
            crc_d        = cfg_init;
            state_d      = S_IDLE;
            settle_cnt_d = '0;
            bit_idx_d    = 3'd7;
        end
    end

    assign crc_out = crc_q;

endmodule
`default_nettype wire
